// File: rtl/pulse_burst_channel_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_burst_channel_if
// Brief    : Host-side timing words and trigger, plus channel status outputs.
// Revision : 1.0
// ============================================================================
interface pulse_burst_channel_if #(
  parameter int W  = 32,
  parameter int CW = 16
);
  logic          trigger_in;
  logic          enable;
  logic [W-1:0]  delay;
  logic [W-1:0]  width;
  logic [W-1:0]  period;
  logic [CW-1:0] count;
  logic          pulse_out;
  logic          running;
  logic          done;
  logic [CW-1:0] pulse_idx;

  modport master (
    output trigger_in, enable, delay, width, period, count,
    input  pulse_out, running, done, pulse_idx
  );

  modport slave (
    input  trigger_in, enable, delay, width, period, count,
    output pulse_out, running, done, pulse_idx
  );
endinterface
`default_nettype wire

// File: rtl/pulse_burst_channel.sv
`default_nettype none
// ============================================================================
// Module   : pulse_burst_channel
// Brief    : Single-channel delay/width/burst pulse generator.
// Revision : 1.0
// ============================================================================
module pulse_burst_channel #(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pulse_burst_channel_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } state_t;

  localparam logic [W-1:0]  c_CNT_ONE = W'(1);
  localparam logic [CW-1:0] c_IDX_ONE = CW'(1);

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_cnt, w_cnt_nxt;
  logic [W-1:0]  r_width, w_width_nxt;
  logic [W-1:0]  r_low, w_low_nxt;
  logic [CW-1:0] r_last, w_last_nxt;
  logic [CW-1:0] r_idx, w_idx_nxt;
  logic          r_pulse, w_pulse_nxt;
  logic          r_running, w_running_nxt;
  logic          r_done, w_done_nxt;

  logic          w_accept;
  logic [W-1:0]  w_low_calc;
  logic [CW-1:0] w_last_calc;

  assign w_accept = bus.trigger_in && bus.enable;

  // max(period, width+1) - width equals max(period - width, 1); this form
  // needs no extra bit even when width is all ones.
  assign w_low_calc  = (bus.period > bus.width) ? (bus.period - bus.width) : c_CNT_ONE;
  assign w_last_calc = (bus.count == '0) ? '0 : (bus.count - c_IDX_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_width   <= '0;
      r_low     <= '0;
      r_last    <= '0;
      r_idx     <= '0;
      r_pulse   <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_width   <= w_width_nxt;
      r_low     <= w_low_nxt;
      r_last    <= w_last_nxt;
      r_idx     <= w_idx_nxt;
      r_pulse   <= w_pulse_nxt;
      r_running <= w_running_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_width_nxt   = r_width;
    w_low_nxt     = r_low;
    w_last_nxt    = r_last;
    w_idx_nxt     = r_idx;
    w_pulse_nxt   = r_pulse;
    w_running_nxt = r_running;
    w_done_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_pulse_nxt   = 1'b0;
        w_running_nxt = 1'b0;
        w_idx_nxt     = '0;
        w_cnt_nxt     = '0;
        if (w_accept) begin
          w_running_nxt = 1'b1;
          if (bus.width == '0) begin
            // Zero width consumes the trigger: one-cycle busy/done, no pulse.
            w_done_nxt = 1'b1;
          end else begin
            w_width_nxt = bus.width;
            w_low_nxt   = w_low_calc;
            w_last_nxt  = w_last_calc;
            if (bus.delay == '0) begin
              w_state_nxt = ST_HIGH;
              w_pulse_nxt = 1'b1;
              w_cnt_nxt   = bus.width;
            end else begin
              w_state_nxt = ST_DELAY;
              w_cnt_nxt   = bus.delay;
            end
          end
        end
      end

      ST_DELAY: begin
        if (r_cnt == c_CNT_ONE) begin
          w_state_nxt = ST_HIGH;
          w_pulse_nxt = 1'b1;
          w_cnt_nxt   = r_width;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end

      ST_HIGH: begin
        if (r_cnt == c_CNT_ONE) begin
          w_pulse_nxt = 1'b0;
          if (r_idx == r_last) begin
            w_state_nxt   = ST_IDLE;
            w_running_nxt = 1'b0;
            w_done_nxt    = 1'b1;
            w_idx_nxt     = '0;
            w_cnt_nxt     = '0;
          end else begin
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = r_low;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end

      ST_LOW: begin
        if (r_cnt == c_CNT_ONE) begin
          w_state_nxt = ST_HIGH;
          w_pulse_nxt = 1'b1;
          w_cnt_nxt   = r_width;
          w_idx_nxt   = r_idx + c_IDX_ONE;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Disabling the channel overrides whatever the sequence would do next.
    if ((r_state != ST_IDLE) && !bus.enable) begin
      w_state_nxt   = ST_IDLE;
      w_pulse_nxt   = 1'b0;
      w_running_nxt = 1'b0;
      w_done_nxt    = 1'b0;
      w_idx_nxt     = '0;
      w_cnt_nxt     = '0;
    end
  end

  assign bus.pulse_out = r_pulse;
  assign bus.running   = r_running;
  assign bus.done      = r_done;
  assign bus.pulse_idx = r_idx;

endmodule
`default_nettype wire
